// File: rtl/wave_measure.sv
// Windowed max/min/Vpp/period measurement of a strobed sample stream,
// presenting one selected value saturated to 0..9999 for a 4-digit display.
module wave_measure #(
    parameter int DATA_W = 12,
    parameter int WINDOW = 4096,
    parameter int HYST   = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        mode,
    output logic [13:0]       result,
    output logic              result_valid,
    output logic              no_signal
);

    localparam int WIN_W = $clog2(WINDOW);
    localparam logic [WIN_W-1:0]  LAST   = WIN_W'(WINDOW - 1);
    localparam logic [DATA_W-1:0] MID    = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W:0]   HYST_X = (DATA_W+1)'(HYST);
    localparam logic [DATA_W:0]   DMAX_X = {1'b0, {DATA_W{1'b1}}};
    localparam logic [CNT_W-1:0]  CMAX   = '1;

    logic [WIN_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] max_q, max_d, min_q, min_d;
    logic [DATA_W-1:0] level_q, level_d;
    logic              armed_q, armed_d;
    logic [CNT_W-1:0]  per_q, per_d, lastp_q, lastp_d;
    logic              seen_q, seen_d;
    logic [1:0]        ev_q, ev_d;
    logic [DATA_W-1:0] lmax_q, lmax_d, lmin_q, lmin_d;
    logic [CNT_W-1:0]  lper_q, lper_d;
    logic              nosig_q, nosig_d;
    logic [13:0]       res_q, res_d;
    logic              vld_q, vld_d;
    logic [1:0]        mode_q, mode_d;

    logic [DATA_W-1:0] mx_s, mn_s;
    logic [DATA_W:0]   lvl_x, lo_x, hi_x, hi_raw, sum_s;
    logic              fire, close;
    logic [31:0]       src;

    // Thresholds are formed one bit wider so they clamp instead of wrapping.
    assign lvl_x  = {1'b0, level_q};
    assign lo_x   = (lvl_x >= HYST_X) ? lvl_x - HYST_X : '0;
    assign hi_raw = lvl_x + HYST_X;
    assign hi_x   = (hi_raw > DMAX_X) ? DMAX_X : hi_raw;

    assign mx_s  = (data > max_q) ? data : max_q;
    assign mn_s  = (data < min_q) ? data : min_q;
    assign sum_s = {1'b0, mx_s} + {1'b0, mn_s};
    assign fire  = sample_en && armed_q && ({1'b0, data} >= hi_x);
    assign close = sample_en && (cnt_q == LAST);

    always_comb begin
        cnt_d   = cnt_q;
        max_d   = max_q;
        min_d   = min_q;
        level_d = level_q;
        armed_d = armed_q;
        per_d   = per_q;
        lastp_d = lastp_q;
        seen_d  = seen_q;
        ev_d    = ev_q;
        lmax_d  = lmax_q;
        lmin_d  = lmin_q;
        lper_d  = lper_q;
        nosig_d = nosig_q;
        res_d   = res_q;
        vld_d   = 1'b0;
        mode_d  = mode;
        src     = '0;
        if (sample_en) begin
            cnt_d = cnt_q + 1'b1;
            max_d = mx_s;
            min_d = mn_s;
            if (fire) begin
                armed_d = 1'b0;
                per_d   = '0;
                seen_d  = 1'b1;
                ev_d    = (ev_q == 2'd2) ? 2'd2 : ev_q + 2'd1;
                if (seen_q)
                    lastp_d = (per_q == CMAX) ? CMAX : per_q + 1'b1;
            end else begin
                if ({1'b0, data} < lo_x)
                    armed_d = 1'b1;
                per_d = (per_q == CMAX) ? CMAX : per_q + 1'b1;
            end
            // Closing sample is already folded into mx_s/mn_s and ev_d.
            if (close) begin
                lmax_d  = mx_s;
                lmin_d  = mn_s;
                nosig_d = (ev_d < 2'd2);
                lper_d  = nosig_d ? '0 : lastp_d;
                level_d = sum_s[DATA_W:1];
                max_d   = '0;
                min_d   = '1;
                ev_d    = '0;
                vld_d   = 1'b1;
            end
        end
        unique case (mode)
            2'd0: src = (lmin_d > lmax_d) ? '0 : 32'(lmax_d - lmin_d);
            2'd1: src = 32'(lmax_d);
            2'd2: src = 32'(lmin_d);
            2'd3: src = 32'(lper_d);
        endcase
        if (vld_d || (mode != mode_q))
            res_d = (src > 32'd9999) ? 14'd9999 : src[13:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            max_q   <= '0;
            min_q   <= '1;
            level_q <= MID;
            armed_q <= 1'b0;
            per_q   <= '0;
            lastp_q <= '0;
            seen_q  <= 1'b0;
            ev_q    <= '0;
            lmax_q  <= '0;
            lmin_q  <= '0;
            lper_q  <= '0;
            nosig_q <= 1'b0;
            res_q   <= '0;
            vld_q   <= 1'b0;
            mode_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            max_q   <= max_d;
            min_q   <= min_d;
            level_q <= level_d;
            armed_q <= armed_d;
            per_q   <= per_d;
            lastp_q <= lastp_d;
            seen_q  <= seen_d;
            ev_q    <= ev_d;
            lmax_q  <= lmax_d;
            lmin_q  <= lmin_d;
            lper_q  <= lper_d;
            nosig_q <= nosig_d;
            res_q   <= res_d;
            vld_q   <= vld_d;
            mode_q  <= mode_d;
        end
    end

    assign result       = res_q;
    assign result_valid = vld_q;
    assign no_signal    = nosig_q;

endmodule

// File: tb/tb_wave_measure.sv
// Directed and randomized bench for wave_measure against a window-level
// reference model (sample queue per window, crossings from threshold rules).
module tb_wave_measure;

    localparam int DW    = 12;
    localparam int WIN   = 32;
    localparam int HY    = 16;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;
    localparam int DMAXI = (1 << DW) - 1;

    logic        clock = 1'b0;
    logic        reset;
    logic        sample_en;
    logic [11:0] data;
    logic [1:0]  mode;
    logic [13:0] result;
    logic        result_valid;
    logic        no_signal;

    always #10 clock = ~clock;

    wave_measure #(
        .DATA_W(DW), .WINDOW(WIN), .HYST(HY), .CNT_W(CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .sample_en   (sample_en),
        .data        (data),
        .mode        (mode),
        .result      (result),
        .result_valid(result_valid),
        .no_signal   (no_signal)
    );

    int checks = 0;
    int errors = 0;

    int win[$];
    int m_level, m_pcnt, m_lastp, m_evs;
    int m_lmax, m_lmin, m_lper, m_res, m_pmode;
    bit m_armed, m_seen, m_nosig, m_vld;
    int nvalid, first_vld;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        win.delete();
        m_level = 1 << (DW - 1);
        m_armed = 0; m_seen = 0; m_pcnt = 0; m_lastp = 0; m_evs = 0;
        m_lmax = 0; m_lmin = 0; m_lper = 0; m_nosig = 0;
        m_res = 0; m_vld = 0; m_pmode = 0;
    endtask

    function automatic int selected(input int m);
        case (m)
            0: return (m_lmin > m_lmax) ? 0 : m_lmax - m_lmin;
            1: return m_lmax;
            2: return m_lmin;
            default: return m_lper;
        endcase
    endfunction

    task automatic model_step(input bit en, input int d, input int m);
        int lo, hi, mx, mn;
        bit close;
        close = 0;
        m_vld = 0;
        if (en) begin
            lo = (m_level - HY < 0) ? 0 : m_level - HY;
            hi = (m_level + HY > DMAXI) ? DMAXI : m_level + HY;
            if (m_armed && d >= hi) begin
                m_armed = 0;
                if (m_seen)
                    m_lastp = (m_pcnt + 1 > CMAX) ? CMAX : m_pcnt + 1;
                m_seen = 1;
                m_pcnt = 0;
                m_evs++;
            end else begin
                if (d < lo) m_armed = 1;
                if (m_pcnt < CMAX) m_pcnt++;
            end
            win.push_back(d);
            if (win.size() == WIN) begin
                mx = 0;
                mn = DMAXI;
                foreach (win[i]) begin
                    if (win[i] > mx) mx = win[i];
                    if (win[i] < mn) mn = win[i];
                end
                m_lmax  = mx;
                m_lmin  = mn;
                m_nosig = (m_evs < 2);
                m_lper  = m_nosig ? 0 : m_lastp;
                m_level = (mx + mn) / 2;
                win.delete();
                m_evs = 0;
                m_vld = 1;
                close = 1;
            end
        end
        if (close || m != m_pmode) begin
            m_res = selected(m);
            if (m_res > 9999) m_res = 9999;
        end
        m_pmode = m;
    endtask

    task automatic step(input bit en, input int d, input int m);
        sample_en = en;
        data      = 12'(d);
        mode      = 2'(m);
        @(posedge clock);
        model_step(en, d, m);
        #1;
        check("result", 32'(result), 32'(m_res));
        check("result_valid", 32'(result_valid), 32'(m_vld));
        check("no_signal", 32'(no_signal), 32'(m_nosig));
        if (result_valid === 1'b1) nvalid++;
    endtask

    task automatic strobe(input int d, input int m, input int gap);
        step(1, d, m);
        for (int g = 0; g < gap; g++) step(0, $urandom_range(0, DMAXI), m);
    endtask

    initial begin
        reset = 1'b1;
        sample_en = 1'b0;
        data = '0;
        mode = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("rst_result", 32'(result), 0);
        check("rst_valid", 32'(result_valid), 0);
        check("rst_nosig", 32'(no_signal), 0);
        reset = 1'b0;

        // constant window, mode max then Vpp
        nvalid = 0;
        for (int i = 0; i < WIN; i++) step(1, 1000, 1);
        check("const_valid_on_last", 32'(result_valid), 1);
        check("const_valid_count", 32'(nvalid), 1);
        check("const_max", 32'(result), 1000);
        step(0, 0, 0);
        check("const_vpp", 32'(result), 0);
        check("mode_no_valid", 32'(result_valid), 0);

        // ramp 50..1600
        for (int i = 0; i < WIN; i++) step(1, 50 * (i + 1), 0);
        check("ramp_vpp", 32'(result), 1550);
        step(0, 0, 2);
        check("ramp_min", 32'(result), 50);

        // 8-sample square wave, strobe every 3rd clock, three windows
        for (int i = 0; i < 3 * WIN; i++)
            strobe(((i % 8) < 4) ? 1000 : 3000, 3, 2);
        check("square_period", 32'(result), 8);
        check("square_nosig", 32'(no_signal), 0);

        // flat signal: no events for two windows
        for (int i = 0; i < 2 * WIN; i++) step(1, 2048, 3);
        check("flat_period", 32'(result), 0);
        check("flat_nosig", 32'(no_signal), 1);

        // single step: exactly one event in the window
        for (int i = 0; i < WIN; i++) step(1, (i < WIN / 2) ? 1000 : 3000, 3);
        check("step_nosig", 32'(no_signal), 1);

        // toggle inside the hysteresis band, then a long period that saturates
        for (int i = 0; i < WIN; i++) step(1, (i % 2) ? 2008 : 1992, 3);
        check("band_nosig", 32'(no_signal), 1);
        for (int i = 0; i < WIN; i++) begin
            if (i == 0 || i == 29) step(1, 1000, 3);
            else if (i == 1 || i == 30) step(1, 3000, 3);
            else step(1, (i % 2) ? 2008 : 1992, 3);
        end
        check("sat_period", 32'(result), CMAX);
        check("sat_nosig", 32'(no_signal), 0);

        // reset in the middle of a window
        for (int i = 0; i < 10; i++) step(1, 500, 1);
        check("pre_reset_result", 32'(result), 3000);
        #3 reset = 1'b1;
        #1;
        check("async_rst_result", 32'(result), 0);
        check("async_rst_valid", 32'(result_valid), 0);
        check("async_rst_nosig", 32'(no_signal), 0);
        model_reset();
        @(posedge clock);
        #1 reset = 1'b0;
        first_vld = 0;
        for (int i = 0; i < WIN; i++) begin
            step(1, 700, 1);
            if (result_valid === 1'b1 && first_vld == 0) first_vld = i + 1;
        end
        check("post_reset_window", 32'(first_vld), WIN);
        check("post_reset_max", 32'(result), 700);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int d, m;
            m = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 3) : m_pmode;
            case ($urandom_range(0, 2))
                0: d = $urandom_range(0, DMAXI);
                1: d = (i % 16 < 8) ? $urandom_range(0, 1500)
                                    : $urandom_range(2600, DMAXI);
                default: d = m_level + $urandom_range(0, 4 * HY) - 2 * HY;
            endcase
            if (d < 0) d = 0;
            if (d > DMAXI) d = DMAXI;
            step($urandom_range(0, 3) != 0, d, m);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
